// File: rtl/pipelined_instruction_decoder_pkg.sv
// Shared decode definitions: opcodes, function/mux encodings and the control-word layout.
package pipelined_instruction_decoder_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned FS_W  = 5;

  // Opcode map
  localparam logic [OPC_W-1:0] OP_NOP = 7'b0000000;
  localparam logic [OPC_W-1:0] OP_MOV = 7'b0000010;
  localparam logic [OPC_W-1:0] OP_ADD = 7'b0000101;
  localparam logic [OPC_W-1:0] OP_ADI = 7'b1100101;
  localparam logic [OPC_W-1:0] OP_AND = 7'b0001000;
  localparam logic [OPC_W-1:0] OP_OR  = 7'b0001010;
  localparam logic [OPC_W-1:0] OP_XOR = 7'b0001100;
  localparam logic [OPC_W-1:0] OP_LD  = 7'b0100001;
  localparam logic [OPC_W-1:0] OP_ST  = 7'b0100000;
  localparam logic [OPC_W-1:0] OP_BZ  = 7'b1000000;
  localparam logic [OPC_W-1:0] OP_JMP = 7'b1100000;

  // Function-unit selects
  localparam logic [FS_W-1:0] FS_MOVA = 5'b00000;
  localparam logic [FS_W-1:0] FS_ADD  = 5'b00010;
  localparam logic [FS_W-1:0] FS_AND  = 5'b01000;
  localparam logic [FS_W-1:0] FS_OR   = 5'b01010;
  localparam logic [FS_W-1:0] FS_XOR  = 5'b01100;

  // Result-mux and branch selects
  localparam logic [1:0] MD_FU   = 2'b00;
  localparam logic [1:0] MD_MEM  = 2'b01;
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_ZERO = 2'b01;
  localparam logic [1:0] BS_JUMP = 2'b11;

  typedef struct packed {
    logic            rw;
    logic [1:0]      md;
    logic [1:0]      bs;
    logic            ps;
    logic            mw;
    logic [FS_W-1:0] fs;
    logic            ma;
    logic            mb;
    logic            cs;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // A drained word must not write, store or branch; the other fields are left alone.
  function automatic ctrl_t drain_ctrl(input ctrl_t c);
    ctrl_t r;
    r    = c;
    r.rw = 1'b0;
    r.mw = 1'b0;
    r.bs = BS_NONE;
    r.ps = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pipelined_instruction_decoder_if.sv
// Decoder bus: upstream (IR/fetch) handshake, downstream (execute) handshake and control word.
//  slave  : the decoder side
//  master : the fetch/execute environment side
interface pipelined_instruction_decoder_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned REG_AW  = 5
) ();

  logic               IN_VALID;
  logic               IN_READY;
  logic [INSTR_W-1:0] IR_instruction;
  logic               FLUSH;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               RW;
  logic               MW;
  logic               PS;
  logic               MA;
  logic               MB;
  logic               CS;
  logic [1:0]         MD;
  logic [1:0]         BS;
  logic [4:0]         FS;
  logic [REG_AW-1:0]  DA;
  logic [REG_AW-1:0]  AA;
  logic [REG_AW-1:0]  BA;
  logic               ILLEGAL;
  logic               STALL;

  modport slave (
    input  IN_VALID, IR_instruction, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, RW, MW, PS, MA, MB, CS, MD, BS, FS,
           DA, AA, BA, ILLEGAL, STALL
  );

  modport master (
    output IN_VALID, IR_instruction, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, RW, MW, PS, MA, MB, CS, MD, BS, FS,
           DA, AA, BA, ILLEGAL, STALL
  );

endinterface

// File: rtl/pipelined_instruction_decoder_decode_rom.sv
// Combinational opcode -> control-word table with an illegal-opcode flag.
//  opcode_i  : instruction opcode
//  ctrl_o    : decoded control bits (NOP for unknown opcodes)
//  illegal_o : opcode not present in the table
module pipelined_instruction_decoder_decode_rom
  import pipelined_instruction_decoder_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o,
  output logic             illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OP_NOP: ;
      OP_MOV: begin ctrl_o.rw = 1'b1; ctrl_o.fs = FS_MOVA; end
      OP_ADD: begin ctrl_o.rw = 1'b1; ctrl_o.fs = FS_ADD;  end
      OP_ADI: begin ctrl_o.rw = 1'b1; ctrl_o.fs = FS_ADD; ctrl_o.mb = 1'b1; end
      OP_AND: begin ctrl_o.rw = 1'b1; ctrl_o.fs = FS_AND;  end
      OP_OR:  begin ctrl_o.rw = 1'b1; ctrl_o.fs = FS_OR;   end
      OP_XOR: begin ctrl_o.rw = 1'b1; ctrl_o.fs = FS_XOR;  end
      OP_LD:  begin ctrl_o.rw = 1'b1; ctrl_o.md = MD_MEM;  end
      OP_ST:  begin ctrl_o.mw = 1'b1; end
      OP_BZ:  begin ctrl_o.bs = BS_ZERO; ctrl_o.mb = 1'b1; ctrl_o.cs = 1'b1; end
      OP_JMP: begin ctrl_o.bs = BS_JUMP; ctrl_o.mb = 1'b1; ctrl_o.cs = 1'b1; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Decode stage: registers the control word behind valid/ready, tracks in-flight register
// writers in a shift-register scoreboard and holds issue on read-after-write hazards.
//  CLK, RESET_N : clock, asynchronous active-low reset
//  bus (slave)  : IN_VALID/IN_READY/IR_instruction from fetch, FLUSH,
//                 OUT_VALID/OUT_READY and the control word to execute, ILLEGAL, STALL
module pipelined_instruction_decoder
  import pipelined_instruction_decoder_pkg::*;
#(
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned OPCODE_W  = 7,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned HAZ_DEPTH = 2,
  parameter bit          R0_ZERO   = 1'b1
) (
  input logic                      CLK,
  input logic                      RESET_N,
  pipelined_instruction_decoder_if.slave bus
);

  // Field positions below the opcode: DA, AA, BA, then unused low bits
  localparam int unsigned DA_LSB = INSTR_W - OPCODE_W - REG_AW;
  localparam int unsigned AA_LSB = DA_LSB - REG_AW;
  localparam int unsigned BA_LSB = AA_LSB - REG_AW;

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] in_da;
  logic [REG_AW-1:0] in_aa;
  logic [REG_AW-1:0] in_ba;
  logic [BA_LSB-1:0] unused_ir_bits;

  assign opcode         = OPC_W'(bus.IR_instruction[INSTR_W-1 -: OPCODE_W]);
  assign in_da          = bus.IR_instruction[DA_LSB +: REG_AW];
  assign in_aa          = bus.IR_instruction[AA_LSB +: REG_AW];
  assign in_ba          = bus.IR_instruction[BA_LSB +: REG_AW];
  assign unused_ir_bits = bus.IR_instruction[BA_LSB-1:0];

  ctrl_t rom_ctrl;
  logic  rom_illegal;

  pipelined_instruction_decoder_decode_rom u_rom (
    .opcode_i  (opcode),
    .ctrl_o    (rom_ctrl),
    .illegal_o (rom_illegal)
  );

  // Output register
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] da_q, da_d;
  logic [REG_AW-1:0] aa_q, aa_d;
  logic [REG_AW-1:0] ba_q, ba_d;
  logic              ill_q, ill_d;
  logic              ov_q, ov_d;

  // Scoreboard of recently issued writers
  logic [HAZ_DEPTH-1:0] sb_wr_q, sb_wr_d;
  logic [REG_AW-1:0]    sb_da_q [HAZ_DEPTH];
  logic [REG_AW-1:0]    sb_da_d [HAZ_DEPTH];

  logic aa_rd, ba_rd, src_hit, hazard, in_ready, fire_in;

  // Hazard detection: compare the sources the incoming word actually reads against
  // the held writer and every live scoreboard entry.
  always_comb begin
    aa_rd   = !rom_ctrl.ma;
    ba_rd   = !rom_ctrl.mb && (rom_ctrl.mw || rom_ctrl.rw || (rom_ctrl.bs != BS_NONE));
    src_hit = 1'b0;
    if (R0_ZERO) begin
      if (in_aa == '0) aa_rd = 1'b0;
      if (in_ba == '0) ba_rd = 1'b0;
    end
    if (ov_q && ctrl_q.rw) begin
      src_hit = src_hit | (aa_rd && (in_aa == da_q)) | (ba_rd && (in_ba == da_q));
    end
    for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
      if (sb_wr_q[i]) begin
        src_hit = src_hit | (aa_rd && (in_aa == sb_da_q[i])) | (ba_rd && (in_ba == sb_da_q[i]));
      end
    end
    hazard = bus.IN_VALID && src_hit;
  end

  assign in_ready     = !bus.FLUSH && !hazard && (!ov_q || bus.OUT_READY);
  assign fire_in      = bus.IN_VALID && in_ready;
  assign bus.IN_READY = in_ready;
  assign bus.STALL    = hazard;

  // Output-register next state: flush, then load, then drain, else hold.
  always_comb begin
    ctrl_d = ctrl_q;
    da_d   = da_q;
    aa_d   = aa_q;
    ba_d   = ba_q;
    ill_d  = ill_q;
    ov_d   = ov_q;
    if (bus.FLUSH) begin
      ov_d   = 1'b0;
      ill_d  = 1'b0;
      ctrl_d = drain_ctrl(ctrl_q);
    end else if (fire_in) begin
      ov_d   = 1'b1;
      ill_d  = rom_illegal;
      ctrl_d = rom_ctrl;
      da_d   = in_da;
      aa_d   = in_aa;
      ba_d   = in_ba;
    end else if (ov_q && bus.OUT_READY) begin
      ov_d   = 1'b0;
      ctrl_d = drain_ctrl(ctrl_q);
    end
  end

  // Scoreboard shift: entry 0 captures the writer leaving this cycle.
  always_comb begin
    sb_wr_d    = sb_wr_q;
    sb_da_d    = sb_da_q;
    sb_wr_d[0] = ov_q && bus.OUT_READY && ctrl_q.rw;
    sb_da_d[0] = da_q;
    for (int i = 1; i < int'(HAZ_DEPTH); i++) begin
      sb_wr_d[i] = sb_wr_q[i-1];
      sb_da_d[i] = sb_da_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_q  <= '0;
      da_q    <= '0;
      aa_q    <= '0;
      ba_q    <= '0;
      ill_q   <= 1'b0;
      ov_q    <= 1'b0;
      sb_wr_q <= '0;
      for (int i = 0; i < int'(HAZ_DEPTH); i++) sb_da_q[i] <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      da_q    <= da_d;
      aa_q    <= aa_d;
      ba_q    <= ba_d;
      ill_q   <= ill_d;
      ov_q    <= ov_d;
      sb_wr_q <= sb_wr_d;
      for (int i = 0; i < int'(HAZ_DEPTH); i++) sb_da_q[i] <= sb_da_d[i];
    end
  end

  assign bus.OUT_VALID = ov_q;
  assign bus.RW        = ctrl_q.rw;
  assign bus.MD        = ctrl_q.md;
  assign bus.BS        = ctrl_q.bs;
  assign bus.PS        = ctrl_q.ps;
  assign bus.MW        = ctrl_q.mw;
  assign bus.FS        = ctrl_q.fs;
  assign bus.MA        = ctrl_q.ma;
  assign bus.MB        = ctrl_q.mb;
  assign bus.CS        = ctrl_q.cs;
  assign bus.DA        = da_q;
  assign bus.AA        = aa_q;
  assign bus.BA        = ba_q;
  assign bus.ILLEGAL   = ill_q;

endmodule
